// File: rtl/chip8_fb_engine.sv
// CHIP-8/SCHIP framebuffer with an XOR sprite engine, a one-row-per-cycle clear,
// and a registered row read port for the display scanner.
module chip8_fb_engine #(
  parameter int FB_W   = 64,
  parameter int FB_H   = 32,
  parameter int WRAP_X = 0,
  parameter int WRAP_Y = 0,
  localparam int X_W   = $clog2(FB_W),
  localparam int Y_W   = $clog2(FB_H)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_clear,
  input  logic [7:0]      cmd_x,
  input  logic [7:0]      cmd_y,
  input  logic [3:0]      cmd_n,
  input  logic            spr_valid,
  output logic            spr_ready,
  input  logic [7:0]      spr_data,
  output logic            done,
  output logic            collision,
  output logic            busy,
  input  logic [Y_W-1:0]  rd_row,
  output logic [FB_W-1:0] rd_data
);

  // Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready, and a
  // sprite row transfers on a cycle where spr_valid && spr_ready; neither side may
  // assume a transfer otherwise, and valid is held by the source until accepted.
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_e;

  state_e                      state_q, state_d;
  logic [7:0]                  x0_q, x0_d, y0_q, y0_d;
  logic [3:0]                  n_q, n_d, r_q, r_d;
  logic [Y_W-1:0]              ptr_q, ptr_d;
  logic                        acc_q, acc_d;
  logic                        done_q, done_d, coll_q, coll_d;
  logic [FB_W-1:0]             rd_q, rd_d;
  logic [FB_H-1:0][FB_W-1:0]   fb_q, fb_d;

  logic [FB_W-1:0] mask, old_row;
  logic [8:0]      col;
  logic [7:0]      row_sum;
  logic            row_ok;
  logic [Y_W-1:0]  row_idx;

  // Sprite byte expanded to a full-width row mask; off-screen columns wrap or drop.
  always_comb begin
    mask = '0;
    col  = '0;
    for (int k = 0; k < 8; k++) begin
      col = {1'b0, x0_q} + 9'(k);
      if (spr_data[3'(7 - k)] && (WRAP_X != 0 || col < 9'(FB_W)))
        mask[col[X_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    row_sum = y0_q + {4'b0, r_q};
    row_ok  = (WRAP_Y != 0) || (row_sum < 8'(FB_H));
    row_idx = row_sum[Y_W-1:0];
    old_row = fb_q[row_idx];
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    n_d     = n_q;
    r_d     = r_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    coll_d  = coll_q;
    fb_d    = fb_q;
    done_d  = (state_q == S_DONE);
    rd_d    = fb_q[rd_row];
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d  = cmd_x % 8'(FB_W);
          y0_d  = cmd_y % 8'(FB_H);
          n_d   = cmd_n;
          r_d   = '0;
          ptr_d = '0;
          acc_d = 1'b0;
          if (cmd_clear)        state_d = S_CLEAR;
          else if (cmd_n == '0) state_d = S_DONE;
          else                  state_d = S_DRAW;
        end
      end
      S_CLEAR: begin
        fb_d[ptr_q] = '0;
        ptr_d       = ptr_q + 1'b1;
        if (ptr_q == Y_W'(FB_H - 1)) state_d = S_DONE;
      end
      S_DRAW: begin
        if (spr_valid) begin
          // A byte landing below the screen in clip mode is still consumed.
          if (row_ok) begin
            fb_d[row_idx] = old_row ^ mask;
            acc_d         = acc_q | (|(old_row & mask));
          end
          r_d = r_q + 1'b1;
          if (r_q == n_q - 4'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        coll_d  = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      n_q     <= '0;
      r_q     <= '0;
      ptr_q   <= '0;
      acc_q   <= 1'b0;
      coll_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      n_q     <= n_d;
      r_q     <= r_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      fb_q    <= fb_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign spr_ready = (state_q == S_DRAW);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign collision = coll_q;
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_chip8_fb_engine.sv
// Bench for chip8_fb_engine: a clip-mode and a wrap-mode instance share one stimulus
// stream and are checked against a pixel-level framebuffer model.
module tb_chip8_fb_engine;
  localparam int W = 64;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_clear = 1'b0;
  logic [7:0] cmd_x = '0, cmd_y = '0;
  logic [3:0] cmd_n = '0;
  logic       spr_valid = 1'b0;
  logic [7:0] spr_data = '0;
  logic [4:0] rd_row = '0;

  logic         cmd_ready0, spr_ready0, done0, coll0, busy0;
  logic         cmd_ready1, spr_ready1, done1, coll1, busy1;
  logic [W-1:0] rd_data0, rd_data1;

  chip8_fb_engine #(.FB_W(W), .FB_H(H), .WRAP_X(0), .WRAP_Y(0)) u_clip (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_clear(cmd_clear), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
    .spr_valid(spr_valid), .spr_ready(spr_ready0), .spr_data(spr_data),
    .done(done0), .collision(coll0), .busy(busy0), .rd_row(rd_row), .rd_data(rd_data0));

  chip8_fb_engine #(.FB_W(W), .FB_H(H), .WRAP_X(1), .WRAP_Y(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_clear(cmd_clear), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
    .spr_valid(spr_valid), .spr_ready(spr_ready1), .spr_data(spr_data),
    .done(done1), .collision(coll1), .busy(busy1), .rd_row(rd_row), .rd_data(rd_data1));

  // Clock and cycle label (value seen at a negedge names the preceding posedge).
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: {done cycle, clip collision, wrap collision}.
  logic [33:0]  exp_q[$];
  logic [W-1:0] rd_q0[$], rd_q1[$];
  logic         rd_issue = 1'b0, rd_pend = 1'b0;
  logic [33:0]  e;
  logic [W-1:0] mdl [2][H];
  logic [7:0]   sbuf [16];
  logic         lc0 = 1'b0, lc1 = 1'b0;
  int           n_cmp = 0, n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel by pixel, clip (m=0) or wrap (m=1) at the edges.
  task automatic model_byte(input int m, input int x0, input int y, input logic [7:0] d,
                            output logic c);
    int yy, xx;
    c  = 1'b0;
    yy = y;
    if (yy >= H) begin
      if (m == 0) return;
      yy = yy % H;
    end
    for (int k = 0; k < 8; k++) begin
      if (d[7-k]) begin
        xx = x0 + k;
        if (xx >= W && m == 0) continue;
        xx = xx % W;
        if (mdl[m][yy][xx]) c = 1'b1;
        mdl[m][yy][xx] = ~mdl[m][yy][xx];
      end
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++)
      for (int y = 0; y < H; y++) mdl[m][y] = '0;
  endtask

  // Monitor: pops expectations whenever the DUTs present done or read data.
  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (reset_n) begin
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {62'b0, done0, done1}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e[33:2]));
          check("done_clip", 64'(done0), 64'd1);
          check("done_wrap", 64'(done1), 64'd1);
          check("coll_clip", 64'(coll0), 64'(e[1]));
          check("coll_wrap", 64'(coll1), 64'(e[0]));
        end
      end
      if (rd_pend) begin
        check("row_clip", rd_data0, rd_q0.pop_front());
        check("row_wrap", rd_data1, rd_q1.pop_front());
      end
    end
  end

  // Driver tasks. All start and end on a negedge.
  task automatic push(input int c, input logic c0, input logic c1);
    exp_q.push_back({32'(c), c0, c1});
    lc0 = c0;
    lc1 = c1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready0 && cmd_ready1) return;
      spr_valid = ($urandom_range(3, 0) == 0);
      spr_data  = 8'($urandom);
      @(negedge clk);
    end
    check("idle_timeout", {62'b0, cmd_ready0, cmd_ready1}, 64'd3);
  endtask

  task automatic issue(input logic clr, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] n, output int ca);
    wait_idle();
    cmd_valid = 1'b1; cmd_clear = clr; cmd_x = x; cmd_y = y; cmd_n = n;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_clear = 1'b0;
    cmd_x = 8'($urandom); cmd_y = 8'($urandom); cmd_n = 4'($urandom);
    ca = cyc;
  endtask

  task automatic do_clear();
    int ca;
    issue(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), ca);
    push(ca + H + 1, 1'b0, 1'b0);
    model_clear();
  endtask

  task automatic feed_byte(input logic [7:0] d, input int x0, input int y,
                           inout logic a0, inout logic a1);
    logic c;
    check("spr_ready", {62'b0, spr_ready0, spr_ready1}, 64'd3);
    spr_valid = 1'b1;
    spr_data  = d;
    @(posedge clk);
    model_byte(0, x0, y, d, c); a0 = a0 | c;
    model_byte(1, x0, y, d, c); a1 = a1 | c;
    @(negedge clk);
    spr_valid = 1'b0;
  endtask

  task automatic do_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                         input int gmin, input int gmax);
    int ca, x0, y0;
    logic a0, a1;
    a0 = 1'b0; a1 = 1'b0;
    issue(1'b0, x, y, n, ca);
    x0 = int'(x) % W;
    y0 = int'(y) % H;
    if (n == 0) begin
      check("n0_spr_ready", {62'b0, spr_ready0, spr_ready1}, 64'd0);
      push(ca + 1, 1'b0, 1'b0);
      return;
    end
    for (int r = 0; r < int'(n); r++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        spr_valid = 1'b0;
        spr_data  = 8'($urandom);
        @(negedge clk);
      end
      feed_byte(sbuf[r], x0, y0 + r, a0, a1);
    end
    push(cyc + 1, a0, a1);
  endtask

  task automatic readback();
    wait_idle();
    spr_valid = 1'b0;
    check("coll_hold_clip", 64'(coll0), 64'(lc0));
    check("coll_hold_wrap", 64'(coll1), 64'(lc1));
    for (int r = 0; r < H; r++) begin
      rd_row   = 5'(r);
      rd_issue = 1'b1;
      rd_q0.push_back(mdl[0][r]);
      rd_q1.push_back(mdl[1][r]);
      @(negedge clk);
    end
    rd_issue = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {62'b0, cmd_ready0, cmd_ready1}, 64'd3);
    check({tag, "_spr_ready"}, {62'b0, spr_ready0, spr_ready1}, 64'd0);
    check({tag, "_busy"}, {62'b0, busy0, busy1}, 64'd0);
    check({tag, "_done"}, {62'b0, done0, done1}, 64'd0);
    check({tag, "_coll"}, {62'b0, coll0, coll1}, 64'd0);
    check({tag, "_rd_clip"}, rd_data0, 64'd0);
    check({tag, "_rd_wrap"}, rd_data1, 64'd0);
  endtask

  initial begin
    int ca;
    logic a0, a1;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Pattern fill, then CLEAR: done lands FB_H+1 cycles after accept.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) sbuf[j] = 8'($urandom);
      do_draw(8'($urandom), 8'($urandom), 4'($urandom_range(15, 1)), 0, 1);
    end
    readback();
    do_clear();
    readback();

    // Same sprite twice: toggles on, then off with collision.
    sbuf[0] = 8'hF0;
    do_draw(8'd0, 8'd0, 4'd1, 0, 0);
    readback();
    do_draw(8'd0, 8'd0, 4'd1, 0, 0);
    readback();

    // Reset in the middle of a DRAW aborts with no done pulse.
    issue(1'b0, 8'd5, 8'd5, 4'd4, ca);
    a0 = 1'b0; a1 = 1'b0;
    feed_byte(8'hAA, 5, 5, a0, a1);
    feed_byte(8'h55, 5, 6, a0, a1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    model_clear();
    lc0 = 1'b0; lc1 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    readback();

    // Edge handling: right-edge clip/wrap, origin reduction, bottom-edge clip/wrap.
    sbuf[0] = 8'hFF;
    do_draw(8'd60, 8'd0, 4'd1, 0, 0);
    readback();
    do_clear();
    sbuf[0] = 8'h80; sbuf[1] = 8'h80;
    do_draw(8'd70, 8'd33, 4'd2, 0, 0);
    sbuf[0] = 8'hFF; sbuf[1] = 8'hC3;
    do_draw(8'd0, 8'd31, 4'd2, 0, 0);
    readback();

    // Gapped sprite stream and the zero-row draw.
    sbuf[0] = 8'h3C; sbuf[1] = 8'h42; sbuf[2] = 8'h81;
    do_draw(8'd10, 8'd12, 4'd3, 2, 2);
    do_draw(8'd20, 8'd20, 4'd0, 0, 0);
    readback();

    // Randomized mix of draws and clears.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        do_clear();
      end else begin
        for (int j = 0; j < 16; j++) sbuf[j] = 8'($urandom);
        do_draw(8'($urandom), 8'($urandom), 4'($urandom_range(15, 0)), 0, 3);
      end
      if (i % 8 == 7) readback();
    end
    readback();

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_done", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
